// File: rtl/seq_div_4by2_pkg.sv
// Shared definitions for the sequential 4-by-2 restoring divider:
// default operand widths and the controller state encoding.
package div_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_M  = 2;
  localparam int DEF_CW = $clog2(DEF_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_4by2_if.sv
// Start/done operand bus of the divider; the requester drives the master
// side and the divider implements the slave side.
interface seq_div_4by2_if
  import div_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
);

  logic         start;
  logic [N-1:0] a;
  logic [M-1:0] b;
  logic [N-1:0] q;
  logic [M-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;

  modport master (
    output start, a, b,
    input  q, r, busy, done, dz
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, dz
  );

endinterface

// File: rtl/seq_div_4by2_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module div_step
  import div_pkg::*;
#(
  parameter int M = DEF_M
) (
  input  logic [M:0]   i_pr,
  input  logic         i_bit,
  input  logic [M-1:0] i_b,
  output logic [M:0]   o_pr,
  output logic         o_qBit
);

  logic [M:0] w_prShift;
  logic [M:0] w_bExt;

  assign w_prShift = {i_pr[M-1:0], i_bit};
  assign w_bExt    = {1'b0, i_b};

  // The shifted remainder is below 2b, so one conditional subtract suffices
  always_comb begin
    o_pr   = w_prShift;
    o_qBit = 1'b0;
    if (w_prShift >= w_bExt) begin
      o_pr   = w_prShift - w_bExt;
      o_qBit = 1'b1;
    end
  end

endmodule

// File: rtl/seq_div_4by2.sv
// Sequential unsigned divider: one quotient bit per clock, MSB first,
// with a start/done handshake and a divide-by-zero shortcut.
module seq_div_4by2
  import div_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_div_4by2_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  state_t       r_state;
  state_t       w_stateNext;
  logic [N-1:0] r_aReg;
  logic [M-1:0] r_bReg;
  logic [M:0]   r_pr;
  logic [N-1:0] r_qWork;
  logic [CW-1:0] r_count;
  logic [N-1:0] r_q;
  logic [M-1:0] r_r;
  logic         r_dz;

  logic [M:0]   w_prNext;
  logic         w_qBit;
  logic [N-1:0] w_qShift;
  logic         w_accept;
  logic         w_lastStep;

  div_step #(.M(M)) u_step (
    .i_pr   (r_pr),
    .i_bit  (r_aReg[N-1]),
    .i_b    (r_bReg),
    .o_pr   (w_prNext),
    .o_qBit (w_qBit)
  );

  assign w_qShift   = {r_qWork[N-2:0], w_qBit};
  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_lastStep = (r_state == RUN) && (r_count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (bus.start) w_stateNext = (bus.b == '0) ? DONE : RUN;
      RUN:  if (r_count == CW'(1)) w_stateNext = DONE;
      DONE: w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Results are loaded on the edge entering DONE, so they are valid with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aReg  <= '0;
      r_bReg  <= '0;
      r_pr    <= '0;
      r_qWork <= '0;
      r_count <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_aReg  <= bus.a;
      r_bReg  <= bus.b;
      r_pr    <= '0;
      r_qWork <= '0;
      r_count <= CW'(N);
      if (bus.b == '0) begin
        r_q  <= '1;
        r_r  <= bus.a[M-1:0];
        r_dz <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_aReg  <= r_aReg << 1;
      r_pr    <= w_prNext;
      r_qWork <= w_qShift;
      r_count <= r_count - CW'(1);
      if (w_lastStep) begin
        r_q  <= w_qShift;
        r_r  <= w_prNext[M-1:0];
        r_dz <= 1'b0;
      end
    end
  end

  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.dz   = r_dz;
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);

endmodule

// File: tb/tb_seq_div_4by2.sv
// Directed bench for seq_div_4by2: latency, results, divide-by-zero,
// ignored starts, mid-run reset and exhaustive/round-trip coverage.
module tb_seq_div_4by2;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;

  seq_div_4by2_if #(.N(4), .M(2)) bus ();

  seq_div_4by2 #(.N(4), .M(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a negedge with the DUT idle; returns at the negedge
  // following the one where done was seen, so the next start is back-to-back.
  task automatic doDiv(input logic [3:0] ia, input logic [1:0] ib,
                       output int edges, output int busyCycles,
                       output logic [3:0] oq, output logic [1:0] orr,
                       output logic odz, output logic doneAfter);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a      = 4'($urandom);
    bus.b      = 2'($urandom);
    edges      = 1;
    busyCycles = 0;
    while (!bus.done && edges < 20) begin
      if (bus.busy) busyCycles++;
      @(negedge clk);
      edges++;
    end
    oq  = bus.q;
    orr = bus.r;
    odz = bus.dz;
    @(negedge clk);
    doneAfter = bus.done;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 4'd0;
    bus.b     = 2'd0;
    #2;
    nCompared++;
    if ({bus.q, bus.r, bus.busy, bus.done, bus.dz} !== 9'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0",
               bus.q, bus.r, bus.busy, bus.done, bus.dz);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int edges, busyCycles;
    logic [3:0] q;
    logic [1:0] r;
    logic dz, doneAfter;
    logic [3:0] va [4] = '{4'd9, 4'd7, 4'd2, 4'd15};
    logic [1:0] vb [4] = '{2'd3, 2'd2, 2'd3, 2'd1};
    logic [3:0] eq [4] = '{4'd3, 4'd3, 4'd0, 4'd15};
    logic [1:0] er [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 4; i++) begin
      doDiv(va[i], vb[i], edges, busyCycles, q, r, dz, doneAfter);
      nCompared++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL basic_result %0d/%0d: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0",
                 va[i], vb[i], q, r, dz, eq[i], er[i]);
      end
      nCompared++;
      if (edges !== 5 || busyCycles !== 4 || doneAfter !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL basic_timing %0d/%0d: got edges=%0d busy=%0d doneAfter=%b, want 5 4 0",
                 va[i], vb[i], edges, busyCycles, doneAfter);
      end
    end
  endtask

  task automatic test_divzero();
    int edges, busyCycles;
    logic [3:0] q;
    logic [1:0] r;
    logic dz, doneAfter;
    doDiv(4'd5, 2'd0, edges, busyCycles, q, r, dz, doneAfter);
    nCompared++;
    if (q !== 4'd15 || r !== 2'd1 || dz !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL divzero_result: got q=%0d r=%0d dz=%b, want q=15 r=1 dz=1", q, r, dz);
    end
    nCompared++;
    if (edges !== 1 || busyCycles !== 0 || doneAfter !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL divzero_timing: got edges=%0d busy=%0d doneAfter=%b, want 1 0 0",
               edges, busyCycles, doneAfter);
    end
    // A following normal division must clear the flag
    doDiv(4'd6, 2'd3, edges, busyCycles, q, r, dz, doneAfter);
    nCompared++;
    if (q !== 4'd2 || r !== 2'd0 || dz !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL divzero_clear: got q=%0d r=%0d dz=%b, want q=2 r=0 dz=0", q, r, dz);
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [3:0] q;
    logic [1:0] r;
    pulses = 0;
    q = 4'hx;
    r = 2'hx;
    bus.start = 1'b1;
    bus.a     = 4'd9;
    bus.b     = 2'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = (i < 2);
      bus.a     = 4'd4;
      bus.b     = 2'd1;
      if (bus.done) begin
        pulses++;
        q = bus.q;
        r = bus.r;
      end
    end
    bus.start = 1'b0;
    nCompared++;
    if (pulses !== 1 || q !== 4'd3 || r !== 2'd0) begin
      nMismatched++;
      $display("[TB] FAIL ignore_start: got pulses=%0d q=%0d r=%0d, want 1 3 0", pulses, q, r);
    end
  endtask

  task automatic test_mid_reset();
    int edges, busyCycles, pulses;
    logic [3:0] q;
    logic [1:0] r;
    logic dz, doneAfter;
    pulses = 0;
    bus.start = 1'b1;
    bus.a     = 4'd9;
    bus.b     = 2'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nCompared++;
    if ({bus.q, bus.r, bus.busy, bus.done, bus.dz} !== 9'd0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0",
               bus.q, bus.r, bus.busy, bus.done, bus.dz);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    nCompared++;
    if (pulses !== 0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_nodone: got %0d done pulses, want 0", pulses);
    end
    doDiv(4'd6, 2'd2, edges, busyCycles, q, r, dz, doneAfter);
    nCompared++;
    if (q !== 4'd3 || r !== 2'd0 || dz !== 1'b0 || edges !== 5) begin
      nMismatched++;
      $display("[TB] FAIL midreset_after: got q=%0d r=%0d dz=%b edges=%0d, want 3 0 0 5",
               q, r, dz, edges);
    end
  endtask

  task automatic test_exhaustive();
    int edges, busyCycles;
    logic [3:0] q;
    logic [1:0] r;
    logic dz, doneAfter;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 1; bi < 4; bi++) begin
        doDiv(4'(ai), 2'(bi), edges, busyCycles, q, r, dz, doneAfter);
        nCompared++;
        if (int'(q) * bi + int'(r) !== ai || int'(r) >= bi || int'(q) !== ai / bi || dz !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL exhaustive %0d/%0d: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0",
                   ai, bi, q, r, dz, ai / bi, ai % bi);
        end
      end
    end
  endtask

  task automatic test_roundtrip();
    int edges, busyCycles;
    logic [3:0] q;
    logic [1:0] r;
    logic dz, doneAfter;
    for (int x = 0; x < 4; x++) begin
      for (int y = 1; y < 4; y++) begin
        doDiv(4'(x * y), 2'(y), edges, busyCycles, q, r, dz, doneAfter);
        nCompared++;
        if (int'(q) !== x || r !== 2'd0) begin
          nMismatched++;
          $display("[TB] FAIL roundtrip %0d*%0d: got q=%0d r=%0d, want q=%0d r=0",
                   x, y, q, r, x);
        end
      end
    end
  endtask

  // Starts issued the first idle cycle after done must each be accepted
  task automatic test_back_to_back();
    int edges1, edges2, busy1, busy2;
    logic [3:0] q1, q2;
    logic [1:0] r1, r2;
    logic dz1, dz2, da1, da2;
    doDiv(4'd14, 2'd3, edges1, busy1, q1, r1, dz1, da1);
    doDiv(4'd11, 2'd2, edges2, busy2, q2, r2, dz2, da2);
    nCompared++;
    if (q1 !== 4'd4 || r1 !== 2'd2 || edges1 !== 5) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first: got q=%0d r=%0d edges=%0d, want 4 2 5", q1, r1, edges1);
    end
    nCompared++;
    if (q2 !== 4'd5 || r2 !== 2'd1 || edges2 !== 5) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second: got q=%0d r=%0d edges=%0d, want 5 1 5", q2, r2, edges2);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_basic();
    test_divzero();
    test_ignore_start();
    test_mid_reset();
    test_exhaustive();
    test_roundtrip();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
